// File: rtl/switch_cell_segmenter.sv
// Byte-stream to 64-byte cell segmenter feeding the switch core data and pointer FIFOs.
// Optional statistics counters are built when SEG_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a sop byte; stray bytes are discarded; s_ready follows !i_cell_bp
// FILL  | packing frame bytes into 128-bit words
// PAD   | writing zero words until the frame ends on a cell boundary
// PTR   | writing the pointer word for the finished frame
// DROP  | frame truncated; discarding bytes through eop, pointer issued on entry
module switch_cell_segmenter #(
    parameter int MAX_CELLS = 23
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [7:0]   s_data,
    input  logic         s_sop,
    input  logic         s_eop,
    input  logic [3:0]   s_portmap,
    input  logic         i_cell_bp,
    output logic [127:0] o_cell_data_fifo_din,
    output logic         o_cell_data_fifo_wr,
    output logic [15:0]  o_cell_ptr_fifo_din,
    output logic         o_cell_ptr_fifo_wr,
`ifdef SEG_STATS_EN
    output logic [31:0]  o_frame_cnt,
    output logic [15:0]  o_trunc_cnt,
`endif
    output logic         o_trunc
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_PAD  = 3'd2,
        S_PTR  = 3'd3,
        S_DROP = 3'd4
    } state_t;

    localparam logic [11:0] BYTE_LAST = 12'(MAX_CELLS * 64 - 1);

    state_t         state_q;
    logic [127:0]   pack_q;
    logic [127:0]   pack_d;
    logic [3:0]     byte_idx_q;
    logic [7:0]     word_cnt_q;
    logic [11:0]    byte_cnt_q;
    logic [3:0]     portmap_q;
    logic           ptr_pend_q;
    logic [127:0]   data_din_q;
    logic           data_wr_q;
    logic [15:0]    ptr_din_q;
    logic           ptr_wr_q;
    logic           trunc_q;
    logic           ready_c;
    logic           accept;
    logic [3:0]     idx_c;

    always_comb begin
        ready_c = 1'b0;
        unique case (state_q)
            S_IDLE:         ready_c = !i_cell_bp;
            S_FILL, S_DROP: ready_c = 1'b1;
            default:        ready_c = 1'b0;
        endcase
    end

    // Held low while reset is asserted so no byte is acknowledged during reset.
    assign s_ready = rstn & ready_c;
    assign accept  = s_valid & s_ready;

    // A sop byte always lands in byte 0 of a fresh word.
    always_comb begin
        pack_d = (state_q == S_IDLE) ? '0 : pack_q;
        idx_c  = (state_q == S_IDLE) ? 4'd0 : byte_idx_q;
        pack_d[{~idx_c, 3'b111} -: 8] = s_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            pack_q     <= '0;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            portmap_q  <= '0;
            ptr_pend_q <= 1'b0;
            data_din_q <= '0;
            data_wr_q  <= 1'b0;
            ptr_din_q  <= '0;
            ptr_wr_q   <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            data_wr_q <= 1'b0;
            ptr_wr_q  <= 1'b0;
            trunc_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept && s_sop) begin
                        portmap_q  <= s_portmap;
                        byte_cnt_q <= 12'd1;
                        if (s_eop) begin
                            data_din_q <= pack_d;
                            data_wr_q  <= 1'b1;
                            pack_q     <= '0;
                            byte_idx_q <= '0;
                            word_cnt_q <= 8'd1;
                            state_q    <= S_PAD;
                        end else begin
                            pack_q     <= pack_d;
                            byte_idx_q <= 4'd1;
                            word_cnt_q <= '0;
                            state_q    <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + 12'd1;
                        if (s_eop || byte_idx_q == 4'd15) begin
                            data_din_q <= pack_d;
                            data_wr_q  <= 1'b1;
                            pack_q     <= '0;
                            byte_idx_q <= '0;
                            word_cnt_q <= word_cnt_q + 8'd1;
                        end else begin
                            pack_q     <= pack_d;
                            byte_idx_q <= byte_idx_q + 4'd1;
                        end
                        // The limit is a multiple of 16 bytes, so the truncating byte always closes a word.
                        if (s_eop) begin
                            state_q <= S_PAD;
                        end else if (byte_cnt_q == BYTE_LAST) begin
                            trunc_q    <= 1'b1;
                            ptr_pend_q <= 1'b1;
                            state_q    <= S_DROP;
                        end
                    end
                end
                S_PAD: begin
                    if (word_cnt_q[1:0] != 2'd0) begin
                        data_din_q <= '0;
                        data_wr_q  <= 1'b1;
                        word_cnt_q <= word_cnt_q + 8'd1;
                    end else begin
                        state_q <= S_PTR;
                    end
                end
                S_PTR: begin
                    ptr_din_q <= {4'b0, portmap_q, 2'b0, word_cnt_q[7:2]};
                    ptr_wr_q  <= 1'b1;
                    state_q   <= S_IDLE;
                end
                S_DROP: begin
                    // Pointer follows the last data word by one cycle.
                    if (ptr_pend_q) begin
                        ptr_din_q  <= {4'b0, portmap_q, 2'b0, word_cnt_q[7:2]};
                        ptr_wr_q   <= 1'b1;
                        ptr_pend_q <= 1'b0;
                    end
                    if (accept && s_eop) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cell_data_fifo_din = data_din_q;
    assign o_cell_data_fifo_wr  = data_wr_q;
    assign o_cell_ptr_fifo_din  = ptr_din_q;
    assign o_cell_ptr_fifo_wr   = ptr_wr_q;
    assign o_trunc              = trunc_q;

`ifdef SEG_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] trunc_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (ptr_wr_q) frame_cnt_q <= frame_cnt_q + 32'd1;
            if (trunc_q)  trunc_cnt_q <= trunc_cnt_q + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_trunc_cnt = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_switch_cell_segmenter.sv
// Directed bench for switch_cell_segmenter: default instance plus a MAX_CELLS=2 instance for truncation.
module tb_switch_cell_segmenter;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0, bp = 1'b0;
    logic [7:0]   s_data = '0;
    logic [3:0]   s_pm = '0;
    logic         rdy, wr, pwr, trunc;
    logic [127:0] din;
    logic [15:0]  pdin;

    logic         v2 = 1'b0, sop2 = 1'b0, eop2 = 1'b0, bp2 = 1'b0;
    logic [7:0]   d2 = '0;
    logic [3:0]   pm2 = '0;
    logic         rdy2, wr2, pwr2, trunc2;
    logic [127:0] din2;
    logic [15:0]  pdin2;

`ifdef SEG_STATS_EN
    logic [31:0] fc, fc2;
    logic [15:0] tc, tc2;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [127:0] dw[$], dw2[$];
    logic [15:0]  pw[$], pw2[$];
    int dw_cyc[$], pw_cyc[$], dw2_cyc[$], pw2_cyc[$];
    int t_cnt = 0, t2_cnt = 0, t2_cyc = 0;

    always #5 clk = ~clk;

    switch_cell_segmenter #(.MAX_CELLS(23)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(rdy), .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop),
        .s_portmap(s_pm), .i_cell_bp(bp),
        .o_cell_data_fifo_din(din), .o_cell_data_fifo_wr(wr),
        .o_cell_ptr_fifo_din(pdin), .o_cell_ptr_fifo_wr(pwr),
`ifdef SEG_STATS_EN
        .o_frame_cnt(fc), .o_trunc_cnt(tc),
`endif
        .o_trunc(trunc)
    );

    switch_cell_segmenter #(.MAX_CELLS(2)) dut2 (
        .clk(clk), .rstn(rstn),
        .s_valid(v2), .s_ready(rdy2), .s_data(d2), .s_sop(sop2), .s_eop(eop2),
        .s_portmap(pm2), .i_cell_bp(bp2),
        .o_cell_data_fifo_din(din2), .o_cell_data_fifo_wr(wr2),
        .o_cell_ptr_fifo_din(pdin2), .o_cell_ptr_fifo_wr(pwr2),
`ifdef SEG_STATS_EN
        .o_frame_cnt(fc2), .o_trunc_cnt(tc2),
`endif
        .o_trunc(trunc2)
    );

    always @(negedge clk) begin
        cyc++;
        if (wr)     begin dw.push_back(din);   dw_cyc.push_back(cyc);  end
        if (pwr)    begin pw.push_back(pdin);  pw_cyc.push_back(cyc);  end
        if (wr2)    begin dw2.push_back(din2); dw2_cyc.push_back(cyc); end
        if (pwr2)   begin pw2.push_back(pdin2); pw2_cyc.push_back(cyc); end
        if (trunc)  t_cnt++;
        if (trunc2) begin t2_cnt++; t2_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until accepted; s_valid stays high afterwards.
    task automatic send(input bit which, input logic [7:0] d, input logic sop, input logic eop,
                        input logic [3:0] pm, output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        if (which) begin v2 = 1'b1; d2 = d; sop2 = sop; eop2 = eop; pm2 = pm; end
        else begin s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop; s_pm = pm; end
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = which ? rdy2 : rdy;
            @(posedge clk);
            #1;
            waited++;
        end
        chk("send_accepted", 128'(acc), 128'(1));
    endtask

    task automatic wait_ptrs(input bit which, input int n);
        int k;
        k = 0;
        while ((which ? pw2.size() : pw.size()) < n && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk("ptr_wait", 128'((which ? pw2.size() : pw.size()) >= n), 128'(1));
    endtask

    task automatic clear_logs();
        dw.delete(); pw.delete(); dw_cyc.delete(); pw_cyc.delete();
        dw2.delete(); pw2.delete(); dw2_cyc.delete(); pw2_cyc.delete();
    endtask

    initial begin
        int w;
        bit seen;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(rdy), 128'(0));
        chk("rst_data_wr", 128'(wr), 128'(0));
        chk("rst_data_din", din, 128'h0);
        chk("rst_ptr", {111'h0, pwr, pdin}, 128'h0);
        chk("rst_trunc", 128'(trunc), 128'(0));
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_ready", 128'(rdy), 128'(1));
        @(posedge clk); #1;

        // 1-byte frame
        clear_logs();
        send(0, 8'hAA, 1, 1, 4'b0010, w);
        s_valid = 1'b0;
        wait_ptrs(0, 1);
        chk("f1_nwords", 128'(dw.size()), 128'(4));
        chk("f1_word0", dw[0], {8'hAA, 120'h0});
        chk("f1_word1", dw[1], 128'h0);
        chk("f1_word3", dw[3], 128'h0);
        chk("f1_nptr", 128'(pw.size()), 128'(1));
        chk("f1_ptr", 128'(pw[0]), 128'(16'h0201));
        chk("f1_ptr_after_data", 128'(pw_cyc[0] > dw_cyc[3]), 128'(1));

        // 64-byte frame, exactly one cell
        clear_logs();
        for (int i = 0; i < 64; i++) send(0, 8'(i), i == 0, i == 63, 4'b1111, w);
        s_valid = 1'b0;
        wait_ptrs(0, 1);
        chk("f64_nwords", 128'(dw.size()), 128'(4));
        chk("f64_word0", dw[0], 128'h000102030405060708090A0B0C0D0E0F);
        chk("f64_word3", dw[3], 128'h303132333435363738393A3B3C3D3E3F);
        chk("f64_ptr", 128'(pw[0]), 128'(16'h0F01));

        // 65-byte frame spills into a second cell
        clear_logs();
        for (int i = 0; i < 65; i++) send(0, 8'(i), i == 0, i == 64, 4'b0001, w);
        s_valid = 1'b0;
        wait_ptrs(0, 1);
        chk("f65_nwords", 128'(dw.size()), 128'(8));
        chk("f65_word3", dw[3], 128'h303132333435363738393A3B3C3D3E3F);
        chk("f65_word4", dw[4], {8'h40, 120'h0});
        chk("f65_word5", dw[5], 128'h0);
        chk("f65_word7", dw[7], 128'h0);
        chk("f65_ptr", 128'(pw[0]), 128'(16'h0102));
        chk("f65_ptr_after_data", 128'(pw_cyc[0] > dw_cyc[7]), 128'(1));

        // Backpressure at frame start
        clear_logs();
        bp = 1'b1;
        s_valid = 1'b1; s_data = 8'h55; s_sop = 1'b1; s_eop = 1'b1; s_pm = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rdy) seen = 1'b1;
        end
        @(posedge clk); #1;
        chk("bp_ready_low", 128'(seen), 128'(0));
        chk("bp_no_writes", 128'(dw.size()), 128'(0));
        bp = 1'b0;
        send(0, 8'h55, 1, 1, 4'b0100, w);
        s_valid = 1'b0;
        chk("bp_release_latency", 128'(w), 128'(1));
        wait_ptrs(0, 1);
        chk("bp_word0", dw[0], {8'h55, 120'h0});
        chk("bp_ptr", 128'(pw[0]), 128'(16'h0401));

        // Stray bytes in IDLE, then back-to-back 1-byte frames
        clear_logs();
        for (int i = 0; i < 3; i++) send(0, 8'hEE, 0, 0, 4'b1111, w);
        send(0, 8'h11, 1, 1, 4'b0011, w);
        send(0, 8'h22, 1, 1, 4'b0101, w);
        s_valid = 1'b0;
        wait_ptrs(0, 2);
        chk("b2b_nwords", 128'(dw.size()), 128'(8));
        chk("b2b_word0", dw[0], {8'h11, 120'h0});
        chk("b2b_word4", dw[4], {8'h22, 120'h0});
        chk("b2b_nptr", 128'(pw.size()), 128'(2));
        chk("b2b_ptr0", 128'(pw[0]), 128'(16'h0301));
        chk("b2b_ptr1", 128'(pw[1]), 128'(16'h0501));
        chk("b2b_ptr0_order", 128'(pw_cyc[0] > dw_cyc[3]), 128'(1));
        chk("b2b_ptr1_order", 128'(pw_cyc[1] > dw_cyc[7]), 128'(1));

        // Truncation on the MAX_CELLS=2 instance
        for (int i = 0; i < 200; i++) send(1, 8'(i), i == 0, i == 199, 4'b1000, w);
        v2 = 1'b0;
        wait_ptrs(1, 1);
        chk("tr_nwords", 128'(dw2.size()), 128'(8));
        chk("tr_word7", dw2[7], 128'h707172737475767778797A7B7C7D7E7F);
        chk("tr_nptr", 128'(pw2.size()), 128'(1));
        chk("tr_ptr", 128'(pw2[0]), 128'(16'h0802));
        chk("tr_pulses", 128'(t2_cnt), 128'(1));
        chk("tr_pulse_at_byte128", 128'(t2_cyc), 128'(dw2_cyc[7]));
        chk("tr_ptr_after_data", 128'(pw2_cyc[0] > dw2_cyc[7]), 128'(1));
        @(negedge clk);
        chk("tr_back_idle_ready", 128'(rdy2), 128'(1));
        chk("main_no_trunc", 128'(t_cnt), 128'(0));

`ifdef SEG_STATS_EN
        chk("stats_trunc_cnt", 128'(tc2), 128'(1));
        chk("stats_frame_cnt", 128'(fc2), 128'(1));
        chk("stats_main_frames", 128'(fc), 128'(6));
        chk("stats_main_truncs", 128'(tc), 128'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
